exe_stage: RTL and testbench

- Execute stage of the 5-stage LoongArch32 pipeline.
- Consumer end of the decode→execute interface: accepts the 158-bit ID-to-EXE bundle and evaluates ALU, multiply and divide operations; divide is a multi-cycle iterative unit.
- Issues data-SRAM requests for loads and stores, and passes the result bundle to MEM.
- Returns the EXE forwarding/hazard bundle to decode; this bundle is what makes decode stall on loads and on in-flight divides.

---
 rtl/exe_stage_pkg.sv | 50 +++++
 rtl/exe_stage_iter_div.sv | 78 +++++++
 rtl/exe_stage.sv | 153 +++++++++++++++
 tb/tb_exe_stage.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/exe_stage_pkg.sv
// rtl/exe_stage_pkg.sv - shared widths, alu_op bit indices, mem_op encodings and divider states
package exe_stage_pkg;

    localparam int ID2EXE_LEN  = 158;
    localparam int EXE2MEM_LEN = 75;
    localparam int EXE_RF_LEN  = 39;
    localparam int ALU_OP_W    = 19;
    localparam int DIV_ITERS   = 32;
    localparam int DIV_CNT_W   = $clog2(DIV_ITERS);

    localparam int OP_ADD   = 0;
    localparam int OP_SUB   = 1;
    localparam int OP_SLT   = 2;
    localparam int OP_SLTU  = 3;
    localparam int OP_AND   = 4;
    localparam int OP_NOR   = 5;
    localparam int OP_OR    = 6;
    localparam int OP_XOR   = 7;
    localparam int OP_SLL   = 8;
    localparam int OP_SRL   = 9;
    localparam int OP_SRA   = 10;
    localparam int OP_LUI   = 11;
    localparam int OP_MUL   = 12;
    localparam int OP_MULH  = 13;
    localparam int OP_MULHU = 14;
    localparam int OP_DIV   = 15;
    localparam int OP_MOD   = 16;
    localparam int OP_DIVU  = 17;
    localparam int OP_MODU  = 18;

    localparam logic [3:0] MEM_LD_B  = 4'd0;
    localparam logic [3:0] MEM_LD_H  = 4'd1;
    localparam logic [3:0] MEM_LD_W  = 4'd2;
    localparam logic [3:0] MEM_ST_B  = 4'd4;
    localparam logic [3:0] MEM_ST_H  = 4'd5;
    localparam logic [3:0] MEM_ST_W  = 4'd6;
    localparam logic [3:0] MEM_LD_BU = 4'd8;
    localparam logic [3:0] MEM_LD_HU = 4'd9;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/exe_stage_iter_div.sv
// rtl/exe_stage_iter_div.sv - iterative restoring divider, one quotient bit per cycle
module iter_div
    import exe_stage_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        ack,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    div_state_e            r_state;
    div_state_e            w_state_nxt;
    logic [DIV_CNT_W-1:0]  r_cnt;
    logic [31:0]           r_rem;
    logic [31:0]           r_quo;
    logic [31:0]           r_dvs;
    logic                  r_q_neg;
    logic                  r_r_neg;
    logic [33:0]           w_trial;
    logic                  w_fits;

    // r_quo shifts the dividend out at the top while quotient bits enter at the bottom
    assign w_trial = {1'b0, r_rem, r_quo[31]} - {2'b00, r_dvs};
    assign w_fits  = ~w_trial[33];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            DIV_IDLE: if (start) w_state_nxt = DIV_BUSY;
            DIV_BUSY: if (r_cnt == DIV_CNT_W'(DIV_ITERS - 1)) w_state_nxt = DIV_DONE;
            DIV_DONE: if (ack) w_state_nxt = DIV_IDLE;
            default:  w_state_nxt = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= DIV_IDLE;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvs   <= '0;
            r_q_neg <= 1'b0;
            r_r_neg <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                DIV_IDLE: begin
                    if (start) begin
                        r_cnt   <= '0;
                        r_rem   <= '0;
                        r_quo   <= signed_op ? abs32(dividend) : dividend;
                        r_dvs   <= signed_op ? abs32(divisor)  : divisor;
                        r_q_neg <= signed_op & (dividend[31] ^ divisor[31]);
                        r_r_neg <= signed_op & dividend[31];
                    end
                end
                DIV_BUSY: begin
                    r_cnt <= r_cnt + 1'b1;
                    r_rem <= w_fits ? w_trial[31:0] : {r_rem[30:0], r_quo[31]};
                    r_quo <= {r_quo[30:0], w_fits};
                end
                default: ;
            endcase
        end
    end

    assign done      = (r_state == DIV_DONE);
    assign quotient  = r_q_neg ? (~r_quo + 32'd1) : r_quo;
    assign remainder = r_r_neg ? (~r_rem + 32'd1) : r_rem;

endmodule

// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - execute stage: ALU, multiply, iterative divide, data-SRAM request, forwarding
module exe_stage
    import exe_stage_pkg::*;
(
    input  logic                   clk,
    input  logic                   resetn,
    output logic                   exe_allowin,
    input  logic                   id_to_exe_valid,
    input  logic [ID2EXE_LEN-1:0]  id_to_exe_zip,
    input  logic                   mem_allowin,
    output logic                   exe_to_mem_valid,
    output logic [EXE2MEM_LEN-1:0] exe_to_mem_zip,
    output logic [EXE_RF_LEN-1:0]  exe_rf_zip,
    output logic                   data_sram_en,
    output logic [3:0]             data_sram_we,
    output logic [31:0]            data_sram_addr,
    output logic [31:0]            data_sram_wdata
);

    logic                  r_exe_valid;
    logic [ID2EXE_LEN-1:0] r_bundle;

    logic [ALU_OP_W-1:0]   w_alu_op;
    logic                  w_res_from_mem;
    logic [31:0]           w_src1;
    logic [31:0]           w_src2;
    logic [3:0]            w_mem_op;
    logic                  w_rf_we;
    logic [4:0]            w_rf_waddr;
    logic [31:0]           w_rkd_value;
    logic [31:0]           w_pc;

    logic                  w_is_div;
    logic                  w_div_signed;
    logic                  w_div_done;
    logic [31:0]           w_quotient;
    logic [31:0]           w_remainder;
    logic                  w_ready_go;
    logic                  w_fire;
    logic                  w_is_ld;
    logic                  w_is_st;

    logic [31:0]           w_add;
    logic [31:0]           w_sub;
    logic                  w_slt;
    logic                  w_sltu;
    logic [31:0]           w_sra;
    logic [63:0]           w_prod;
    logic [31:0]           w_exe_result;
    logic [3:0]            w_st_we;
    logic [31:0]           w_st_wdata;

    assign {w_alu_op, w_res_from_mem, w_src1, w_src2, w_mem_op,
            w_rf_we, w_rf_waddr, w_rkd_value, w_pc} = r_bundle;

    assign w_is_div     = |w_alu_op[OP_MODU:OP_DIV];
    assign w_div_signed = w_alu_op[OP_DIV] | w_alu_op[OP_MOD];
    assign w_ready_go   = ~w_is_div | w_div_done;
    assign exe_allowin  = ~r_exe_valid | (w_ready_go & mem_allowin);
    assign w_fire       = r_exe_valid & w_ready_go & mem_allowin;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_exe_valid <= 1'b0;
            r_bundle    <= '0;
        end else if (exe_allowin) begin
            r_exe_valid <= id_to_exe_valid;
            if (id_to_exe_valid) r_bundle <= id_to_exe_zip;
        end
    end

    iter_div u_div (
        .clk       (clk),
        .resetn    (resetn),
        .start     (r_exe_valid & w_is_div),
        .signed_op (w_div_signed),
        .dividend  (w_src1),
        .divisor   (w_src2),
        .ack       (w_fire),
        .done      (w_div_done),
        .quotient  (w_quotient),
        .remainder (w_remainder)
    );

    assign w_add  = w_src1 + w_src2;
    assign w_sub  = w_src1 - w_src2;
    assign w_slt  = $signed(w_src1) < $signed(w_src2);
    assign w_sltu = w_src1 < w_src2;
    assign w_sra  = $signed(w_src1) >>> w_src2[4:0];

    // One 64-bit product serves all three multiplies; only mulh.w sign-extends its operands
    assign w_prod = {{32{w_alu_op[OP_MULH] & w_src1[31]}}, w_src1}
                  * {{32{w_alu_op[OP_MULH] & w_src2[31]}}, w_src2};

    always_comb begin
        w_exe_result = '0;
        w_exe_result = ({32{w_alu_op[OP_ADD]}}   & w_add)
                     | ({32{w_alu_op[OP_SUB]}}   & w_sub)
                     | ({32{w_alu_op[OP_SLT]}}   & {31'd0, w_slt})
                     | ({32{w_alu_op[OP_SLTU]}}  & {31'd0, w_sltu})
                     | ({32{w_alu_op[OP_AND]}}   & (w_src1 & w_src2))
                     | ({32{w_alu_op[OP_NOR]}}   & ~(w_src1 | w_src2))
                     | ({32{w_alu_op[OP_OR]}}    & (w_src1 | w_src2))
                     | ({32{w_alu_op[OP_XOR]}}   & (w_src1 ^ w_src2))
                     | ({32{w_alu_op[OP_SLL]}}   & (w_src1 << w_src2[4:0]))
                     | ({32{w_alu_op[OP_SRL]}}   & (w_src1 >> w_src2[4:0]))
                     | ({32{w_alu_op[OP_SRA]}}   & w_sra)
                     | ({32{w_alu_op[OP_LUI]}}   & w_src2)
                     | ({32{w_alu_op[OP_MUL]}}   & w_prod[31:0])
                     | ({32{w_alu_op[OP_MULH]}}  & w_prod[63:32])
                     | ({32{w_alu_op[OP_MULHU]}} & w_prod[63:32])
                     | ({32{w_alu_op[OP_DIV]  | w_alu_op[OP_DIVU]}} & w_quotient)
                     | ({32{w_alu_op[OP_MOD]  | w_alu_op[OP_MODU]}} & w_remainder);
    end

    assign w_is_ld = w_res_from_mem;
    assign w_is_st = (w_mem_op == MEM_ST_B) | (w_mem_op == MEM_ST_H) | (w_mem_op == MEM_ST_W);

    always_comb begin
        w_st_we    = 4'h0;
        w_st_wdata = w_rkd_value;
        case (w_mem_op)
            MEM_ST_B: begin
                w_st_we    = 4'b0001 << w_exe_result[1:0];
                w_st_wdata = {4{w_rkd_value[7:0]}};
            end
            MEM_ST_H: begin
                w_st_we    = w_exe_result[1] ? 4'b1100 : 4'b0011;
                w_st_wdata = {2{w_rkd_value[15:0]}};
            end
            MEM_ST_W: begin
                w_st_we    = 4'hF;
                w_st_wdata = w_rkd_value;
            end
            default: ;
        endcase
    end

    // Gating on the MEM handshake issues exactly one request per instruction
    assign data_sram_en    = w_fire & (w_is_ld | w_is_st);
    assign data_sram_we    = data_sram_en ? w_st_we : 4'h0;
    assign data_sram_addr  = w_exe_result;
    assign data_sram_wdata = w_st_wdata;

    assign exe_to_mem_valid = r_exe_valid & w_ready_go;
    assign exe_to_mem_zip   = {w_res_from_mem, w_mem_op, w_rf_we, w_rf_waddr, w_exe_result, w_pc};

    assign exe_rf_zip = {r_exe_valid & (w_res_from_mem | (w_is_div & ~w_div_done)),
                         r_exe_valid & w_rf_we,
                         w_rf_waddr,
                         w_exe_result};

endmodule

// File: tb/tb_exe_stage.sv
// tb/tb_exe_stage.sv - directed vector bench for exe_stage
module tb_exe_stage;

    logic         clk = 1'b0;
    logic         resetn;
    logic         exe_allowin;
    logic         id_to_exe_valid;
    logic [157:0] id_to_exe_zip;
    logic         mem_allowin;
    logic         exe_to_mem_valid;
    logic [74:0]  exe_to_mem_zip;
    logic [38:0]  exe_rf_zip;
    logic         data_sram_en;
    logic [3:0]   data_sram_we;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    exe_stage dut (
        .clk              (clk),
        .resetn           (resetn),
        .exe_allowin      (exe_allowin),
        .id_to_exe_valid  (id_to_exe_valid),
        .id_to_exe_zip    (id_to_exe_zip),
        .mem_allowin      (mem_allowin),
        .exe_to_mem_valid (exe_to_mem_valid),
        .exe_to_mem_zip   (exe_to_mem_zip),
        .exe_rf_zip       (exe_rf_zip),
        .data_sram_en     (data_sram_en),
        .data_sram_we     (data_sram_we),
        .data_sram_addr   (data_sram_addr),
        .data_sram_wdata  (data_sram_wdata)
    );

    typedef struct {
        logic [18:0] op;
        logic [31:0] s1;
        logic [31:0] s2;
        logic        rfm;
        logic [3:0]  mop;
        logic        rfwe;
        logic [4:0]  wa;
        logic [31:0] rkd;
        logic [31:0] res;
        logic        en;
        logic [3:0]  we;
        logic [31:0] wdata;
    } vec_t;

    vec_t vecs[24];
    int   nvec = 0;

    function automatic logic [18:0] opb(input int k);
        return 19'(1) << k;
    endfunction

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic addv(input logic [18:0] op, input logic [31:0] s1, input logic [31:0] s2,
                        input logic rfm, input logic [3:0] mop, input logic rfwe,
                        input logic [31:0] rkd, input logic [31:0] res,
                        input logic en, input logic [3:0] we, input logic [31:0] wdata);
        vecs[nvec] = '{op, s1, s2, rfm, mop, rfwe, 5'(nvec + 1), rkd, res, en, we, wdata};
        nvec++;
    endtask

    task automatic issue(input logic [18:0] op, input logic [31:0] s1, input logic [31:0] s2,
                         input logic rfm, input logic [3:0] mop, input logic rfwe,
                         input logic [4:0] wa, input logic [31:0] rkd, input logic [31:0] pc);
        @(negedge clk);
        id_to_exe_valid = 1'b1;
        id_to_exe_zip   = {op, rfm, s1, s2, mop, rfwe, wa, rkd, pc};
        @(posedge clk);
        #1;
        id_to_exe_valid = 1'b0;
    endtask

    task automatic do_div(input string nm, input logic [18:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int hold);
        int cyc;
        int blk_bad;
        mem_allowin = (hold == 0);
        issue(op, a, b, 1'b0, 4'd0, 1'b1, 5'd9, 32'd0, 32'h1c000100);
        cyc = 0;
        blk_bad = 0;
        while (!exe_to_mem_valid && cyc < 100) begin
            if (exe_rf_zip[38] !== 1'b1) blk_bad++;
            @(posedge clk);
            #1;
            cyc++;
        end
        check({nm, "_latency"}, 80'(cyc), 80'(33));
        check({nm, "_block_busy"}, 80'(blk_bad), 80'(0));
        check({nm, "_block_done"}, 80'(exe_rf_zip[38]), 80'(0));
        check({nm, "_result"}, 80'(exe_to_mem_zip[63:32]), 80'(exp));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check($sformatf("%s_hold%0d", nm, h), 80'({exe_to_mem_valid, exe_to_mem_zip[63:32]}),
                  80'({1'b1, exp}));
        end
        mem_allowin = 1'b1;
        @(posedge clk);
        #1;
        check({nm, "_handoff"}, 80'(exe_to_mem_valid), 80'(0));
    endtask

    initial begin
        logic [31:0] pc;
        int          pulses;

        resetn          = 1'b0;
        id_to_exe_valid = 1'b0;
        id_to_exe_zip   = '0;
        mem_allowin     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 80'({exe_to_mem_valid, data_sram_en, data_sram_we, exe_rf_zip[38:37], exe_allowin}),
              80'({1'b0, 1'b0, 4'h0, 2'b00, 1'b1}));
        @(negedge clk);
        resetn = 1'b1;

        addv(opb(0),  32'd5,        32'd7,        0, 4'd0, 1, 32'd0, 32'd12,       0, 4'h0, 32'd0);
        addv(opb(1),  32'd5,        32'd7,        0, 4'd0, 1, 32'd0, 32'hFFFFFFFE, 0, 4'h0, 32'd0);
        addv(opb(2),  32'hFFFFFFFF, 32'd1,        0, 4'd0, 1, 32'd0, 32'd1,        0, 4'h0, 32'd0);
        addv(opb(3),  32'hFFFFFFFF, 32'd1,        0, 4'd0, 1, 32'd0, 32'd0,        0, 4'h0, 32'd0);
        addv(opb(4),  32'hF0F0F0F0, 32'hFF00FF00, 0, 4'd0, 1, 32'd0, 32'hF000F000, 0, 4'h0, 32'd0);
        addv(opb(5),  32'hF0F0F0F0, 32'h0F0F0000, 0, 4'd0, 1, 32'd0, 32'h00000F0F, 0, 4'h0, 32'd0);
        addv(opb(6),  32'hF0F0F0F0, 32'h0F0F0000, 0, 4'd0, 1, 32'd0, 32'hFFFFF0F0, 0, 4'h0, 32'd0);
        addv(opb(7),  32'hF0F0F0F0, 32'hFF00FF00, 0, 4'd0, 1, 32'd0, 32'h0FF00FF0, 0, 4'h0, 32'd0);
        addv(opb(8),  32'd1,        32'h24,       0, 4'd0, 1, 32'd0, 32'h10,       0, 4'h0, 32'd0);
        addv(opb(9),  32'h80000000, 32'd31,       0, 4'd0, 1, 32'd0, 32'd1,        0, 4'h0, 32'd0);
        addv(opb(10), 32'h80000000, 32'd4,        0, 4'd0, 1, 32'd0, 32'hF8000000, 0, 4'h0, 32'd0);
        addv(opb(11), 32'd0,        32'h12345000, 0, 4'd0, 1, 32'd0, 32'h12345000, 0, 4'h0, 32'd0);
        addv(opb(12), 32'hFFFFFFFF, 32'd2,        0, 4'd0, 1, 32'd0, 32'hFFFFFFFE, 0, 4'h0, 32'd0);
        addv(opb(13), 32'hFFFFFFFF, 32'd2,        0, 4'd0, 1, 32'd0, 32'hFFFFFFFF, 0, 4'h0, 32'd0);
        addv(opb(14), 32'hFFFFFFFF, 32'd2,        0, 4'd0, 1, 32'd0, 32'd1,        0, 4'h0, 32'd0);
        addv(19'd0,   32'd5,        32'd7,        0, 4'd0, 1, 32'd0, 32'd0,        0, 4'h0, 32'd0);
        addv(opb(0),  32'h2000,     32'd2,        0, 4'd5, 0, 32'hAABBCCDD, 32'h2002, 1, 4'b1100, 32'hCCDDCCDD);
        addv(opb(0),  32'h2000,     32'd0,        0, 4'd5, 0, 32'hAABBCCDD, 32'h2000, 1, 4'b0011, 32'hCCDDCCDD);
        addv(opb(0),  32'h3000,     32'd4,        0, 4'd6, 0, 32'h11223344, 32'h3004, 1, 4'hF,    32'h11223344);
        addv(opb(0),  32'h4000,     32'd8,        1, 4'd2, 1, 32'd0,        32'h4008, 1, 4'h0,    32'd0);

        mem_allowin = 1'b1;
        for (int i = 0; i < nvec; i++) begin
            pc = 32'h1c000000 + 32'(i * 4);
            issue(vecs[i].op, vecs[i].s1, vecs[i].s2, vecs[i].rfm, vecs[i].mop, vecs[i].rfwe,
                  vecs[i].wa, vecs[i].rkd, pc);
            check($sformatf("v%0d_valid", i), 80'(exe_to_mem_valid), 80'(1));
            check($sformatf("v%0d_mem_zip", i), 80'(exe_to_mem_zip),
                  80'({vecs[i].rfm, vecs[i].mop, vecs[i].rfwe, vecs[i].wa, vecs[i].res, pc}));
            check($sformatf("v%0d_rf_zip", i), 80'(exe_rf_zip),
                  80'({vecs[i].rfm, vecs[i].rfwe, vecs[i].wa, vecs[i].res}));
            check($sformatf("v%0d_sram", i), 80'({data_sram_en, data_sram_we}),
                  80'({vecs[i].en, vecs[i].we}));
            if (vecs[i].en) begin
                check($sformatf("v%0d_addr", i), 80'(data_sram_addr), 80'(vecs[i].res));
                if (vecs[i].we != 4'h0)
                    check($sformatf("v%0d_wdata", i), 80'(data_sram_wdata), 80'(vecs[i].wdata));
            end
        end

        // st.b with MEM ready: single strobe
        mem_allowin = 1'b1;
        issue(opb(0), 32'h1000, 32'd3, 1'b0, 4'd4, 1'b0, 5'd0, 32'h12345678, 32'h1c000200);
        check("stb_we", 80'({data_sram_en, data_sram_we, data_sram_addr}), 80'({1'b1, 4'b1000, 32'h1003}));
        check("stb_wdata", 80'(data_sram_wdata), 80'(32'h78787878));
        pulses = int'(data_sram_en);
        repeat (3) begin
            @(posedge clk);
            #1;
            pulses += int'(data_sram_en);
        end
        check("stb_pulses", 80'(pulses), 80'(1));

        // st.b with MEM stalled: strobe waits for allowin
        mem_allowin = 1'b0;
        issue(opb(0), 32'h1000, 32'd3, 1'b0, 4'd4, 1'b0, 5'd0, 32'h12345678, 32'h1c000204);
        check("stb_stall0", 80'({data_sram_en, data_sram_we, exe_allowin}), 80'({1'b0, 4'h0, 1'b0}));
        @(posedge clk);
        #1;
        check("stb_stall1", 80'({data_sram_en, exe_to_mem_valid}), 80'({1'b0, 1'b1}));
        mem_allowin = 1'b1;
        #1;
        check("stb_release", 80'({data_sram_en, data_sram_we}), 80'({1'b1, 4'b1000}));
        @(posedge clk);
        #1;
        check("stb_after", 80'({data_sram_en, exe_to_mem_valid}), 80'({1'b0, 1'b0}));

        do_div("divw",   opb(15), 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 3);
        do_div("modw",   opb(16), 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 0);
        do_div("divwu0", opb(17), 32'd5,        32'd0,        32'hFFFFFFFF, 0);
        do_div("modwu0", opb(18), 32'd5,        32'd0,        32'd5,        1);
        do_div("divovf", opb(15), 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0);
        do_div("modovf", opb(16), 32'h80000000, 32'hFFFFFFFF, 32'd0,        0);
        do_div("divu_big", opb(17), 32'hFFFFFFFF, 32'd16,     32'h0FFFFFFF, 0);

        // reset in the middle of a divide
        mem_allowin = 1'b1;
        issue(opb(15), 32'd100, 32'd7, 1'b0, 4'd0, 1'b1, 5'd3, 32'd0, 32'h1c000300);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        check("rst_mid_busy", 80'(exe_rf_zip[38]), 80'(1));
        resetn = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_state", 80'({exe_to_mem_valid, exe_rf_zip[38:37], data_sram_en, exe_allowin}),
              80'({1'b0, 2'b00, 1'b0, 1'b1}));
        @(negedge clk);
        resetn = 1'b1;
        do_div("div_after_rst", opb(15), 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 0);
        do_div("mod_after_rst", opb(16), 32'd100, 32'hFFFFFFF9, 32'd2,        0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
